lsu_bus_bridge: RTL and testbench

//  Load/store unit between the memory stage and an external data bus with valid/ready handshake.

---
 rtl/lsu_bus_bridge.sv | 248 ++++++++++++++++++++++++
 tb/tb_lsu_bus_bridge.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_bridge.sv
// Load/store bridge between the M stage and a valid/ready data bus.
// Aligns stores onto byte lanes with strobes, extracts and extends load
// data, and stalls the pipeline until the bus completes, the access times
// out, or the access is rejected as misaligned.
//
// Handshake: bus_req_o and all bus_* request fields are held stable from the
// cycle after acceptance in IDLE until a cycle where bus_ready_i=1 (request
// transfer). The response transfer is any cycle with bus_rvalid_i=1 after
// (or in the same cycle as) the request transfer; bus_rvalid_i seen before
// the request transfer, or while idle, is ignored.
module lsu_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic        timeout_o,
  output logic        bus_req_o,
  input  logic        bus_ready_i,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_wstrb_o,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       lane_q, lane_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;

  logic             misaligned;
  logic [31:0]      st_wdata;
  logic [3:0]       st_wstrb;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_data;
  logic             in_idle;
  logic             accept;
  logic             cnt_last;

  // Alignment check on the incoming access size (funct3[1:0]: 0=B, 1=H, 2=W).
  always_comb begin
    misaligned = 1'b0;
    case (funct3_i[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr_i[0];
      default: misaligned = |addr_i[1:0];
    endcase
  end

  // Store formatting: replicate the data across lanes and pick the strobes.
  always_comb begin
    st_wdata = wdata_i;
    st_wstrb = 4'b1111;
    case (funct3_i[1:0])
      2'b00: begin
        st_wdata = {4{wdata_i[7:0]}};
        st_wstrb = 4'b0001 << addr_i[1:0];
      end
      2'b01: begin
        st_wdata = {2{wdata_i[15:0]}};
        st_wstrb = 4'b0011 << addr_i[1:0];
      end
      default: begin
        st_wdata = wdata_i;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Load lane selection using the lane captured with the request.
  always_comb begin
    ld_byte = bus_rdata_i[7:0];
    case (lane_q)
      2'd0:    ld_byte = bus_rdata_i[7:0];
      2'd1:    ld_byte = bus_rdata_i[15:8];
      2'd2:    ld_byte = bus_rdata_i[23:16];
      default: ld_byte = bus_rdata_i[31:24];
    endcase
    ld_half = lane_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
  end

  // Load extension by the captured funct3: B/H signed, BU/HU unsigned, W raw.
  always_comb begin
    ld_data = bus_rdata_i;
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = bus_rdata_i;
    endcase
  end

  assign in_idle  = (state_q == S_IDLE);
  assign accept   = in_idle && mem_valid_i && !misaligned;
  assign cnt_last = (cnt_q == CNT_LAST);

  // Next-state and registered-output logic for the access sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    tmo_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_REQ;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = mem_write_i;
          addr_d  = {addr_i[31:2], 2'b00};
          wdata_d = mem_write_i ? st_wdata : 32'd0;
          wstrb_d = mem_write_i ? st_wstrb : 4'b0000;
          f3_d    = funct3_i;
          lane_d  = addr_i[1:0];
        end
      end

      S_REQ: begin
        if (bus_ready_i && bus_rvalid_i) begin
          // Request and response in the same cycle: finish immediately.
          state_d = S_DONE;
          req_d   = 1'b0;
          done_d  = 1'b1;
          rdata_d = we_q ? 32'd0 : ld_data;
        end else if (cnt_last) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          done_d  = 1'b1;
          tmo_d   = 1'b1;
          rdata_d = 32'd0;
        end else if (bus_ready_i) begin
          state_d = S_WAIT;
          req_d   = 1'b0;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end

      S_WAIT: begin
        if (bus_rvalid_i) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          rdata_d = we_q ? 32'd0 : ld_data;
        end else if (cnt_last) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          tmo_d   = 1'b1;
          rdata_d = 32'd0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        // The instruction in M advances at this edge; its mem_valid_i is stale.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'b0000;
      f3_q    <= 3'b000;
      lane_q  <= 2'b00;
      rdata_q <= 32'd0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  assign stall_o     = accept || (state_q == S_REQ) || (state_q == S_WAIT);
  assign misalign_o  = in_idle && mem_valid_i && misaligned;
  assign done_o      = done_q;
  assign timeout_o   = tmo_q;
  assign rdata_o     = rdata_q;
  assign bus_req_o   = req_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign bus_wstrb_o = wstrb_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Directed bench for lsu_bus_bridge. A transaction-level model predicts,
// from the access description and the bus response timing, the cycle window
// of stall/request, the completion cycle, bus fields and load result.
module tb_lsu_bus_bridge;

  localparam int TO    = 255;
  localparam int NEVER = 100000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, done_o, misalign_o, timeout_o;
  logic [31:0] rdata_o;
  logic        bus_req_o, bus_ready_i, bus_we_o, bus_rvalid_i;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]  bus_wstrb_o;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  lsu_bus_bridge #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(mem_valid_i), .mem_write_i(mem_write_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o),
    .misalign_o(misalign_o), .timeout_o(timeout_o),
    .bus_req_o(bus_req_o), .bus_ready_i(bus_ready_i), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic [31:0] exp_q[$];  // expected rdata_o per completion, in order

  bit          m_active = 1'b0;
  int          m_c0, m_ready, m_done;
  bit          m_tmo;
  bit          m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
    int n = 1 << f3[1:0];
    return (int'(a[1:0]) % n) != 0;
  endfunction

  function automatic logic [3:0] st_strb(input logic [2:0] f3, input int lane);
    int n = 1 << f3[1:0];
    return 4'(((1 << n) - 1) << lane);
  endfunction

  function automatic logic [31:0] st_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int n = 1 << f3[1:0];
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ld_model(input logic [2:0] f3, input int lane, input logic [31:0] w);
    int     n = 1 << f3[1:0];
    longint v, span;
    if (n >= 4) return w;
    span = longint'(1) << (8 * n);
    v = (longint'(w) >> (8 * lane)) % span;
    if (!f3[2] && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // One compare process: every cycle, outputs vs. the transaction model.
  always @(negedge clk) begin
    bit e_stall, e_done, e_req, e_tmo, e_mis;
    if (chk_en) begin
      if (m_active) begin
        e_stall = (cyc >= m_c0) && (cyc < m_done);
        e_done  = (cyc == m_done);
        e_req   = (cyc > m_c0) && (cyc <= m_ready) && (cyc < m_done);
        e_tmo   = e_done && m_tmo;
        e_mis   = 1'b0;
      end else begin
        e_mis   = mem_valid_i && is_mis(funct3_i, addr_i);
        e_stall = mem_valid_i && !e_mis;
        e_done  = 1'b0;
        e_req   = 1'b0;
        e_tmo   = 1'b0;
      end
      chk("stall_o", stall_o, e_stall);
      chk("done_o", done_o, e_done);
      chk("timeout_o", timeout_o, e_tmo);
      chk("misalign_o", misalign_o, e_mis);
      chk("bus_req_o", bus_req_o, e_req);
      if (e_req) begin
        chk("bus_addr_o", bus_addr_o, m_addr);
        chk("bus_we_o", bus_we_o, m_we);
        chk("bus_wstrb_o", bus_wstrb_o, m_wstrb);
        if (m_we) chk("bus_wdata_o", bus_wdata_o, m_wdata);
      end
      if (e_done) begin
        if (exp_q.size() == 0) chk("exp_q_empty", 32'd1, 32'd0);
        else chk("rdata_o", rdata_o, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // rd: cycles in REQ before bus_ready_i; rv: cycles after ready until rvalid.
  task automatic run_access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input int rd, input int rv,
                            input logic [31:0] rword, input bit stray, input int abort_rel,
                            input bit use_lit, input logic [31:0] lit_rdata, input bit lit_tmo,
                            input logic [31:0] lit_addr, input logic [3:0] lit_strb,
                            input logic [31:0] lit_wdata);
    int c0, rdy_c, cmp_c, done_c, abort_c;
    bit tmo;
    @(posedge clk); #1;
    c0      = cyc;
    rdy_c   = c0 + 1 + rd;
    cmp_c   = rdy_c + rv;
    tmo     = (rd + rv + 1) > TO;
    done_c  = tmo ? c0 + 1 + TO : cmp_c + 1;
    abort_c = (abort_rel < 0) ? -1 : c0 + abort_rel;
    m_c0 = c0; m_ready = rdy_c; m_done = done_c; m_tmo = tmo;
    m_we    = we;
    m_addr  = (a / 4) * 4;
    m_wstrb = we ? st_strb(f3, int'(a % 4)) : 4'b0000;
    m_wdata = st_data(f3, wd);
    exp_q.push_back((we || tmo) ? 32'd0 : ld_model(f3, int'(a % 4), rword));
    m_active = 1'b1;
    mem_valid_i = 1'b1; mem_write_i = we; funct3_i = f3; addr_i = a; wdata_i = wd;
    for (int c = c0; c <= done_c; c++) begin
      if (c != c0) begin @(posedge clk); #1; end
      bus_ready_i  = (c == rdy_c);
      bus_rdata_i  = rword;
      bus_rvalid_i = (c == cmp_c) || (stray && rd > 0 && c == c0 + 1);
      if (c == abort_c) rst = 1'b0;
      if (use_lit && c == c0 + 1) begin
        @(negedge clk);
        chk("lit_bus_addr", bus_addr_o, lit_addr);
        chk("lit_bus_wstrb", bus_wstrb_o, lit_strb);
        if (we) chk("lit_bus_wdata", bus_wdata_o, lit_wdata);
      end
      if (use_lit && c == done_c) begin
        @(negedge clk);
        chk("lit_rdata", rdata_o, lit_rdata);
        chk("lit_timeout", timeout_o, lit_tmo);
      end
      if (c == abort_c) break;
    end
    @(posedge clk); #1;
    m_active = 1'b0;
    rst = 1'b1;
    mem_valid_i = 1'b0; bus_ready_i = 1'b0; bus_rvalid_i = 1'b0;
    if (abort_c >= 0) exp_q.delete();
  endtask

  task automatic try_misaligned(input bit we, input logic [2:0] f3, input logic [31:0] a);
    @(posedge clk); #1;
    mem_valid_i = 1'b1; mem_write_i = we; funct3_i = f3; addr_i = a; wdata_i = 32'h5555_AAAA;
    @(negedge clk);
    chk("lit_misalign", misalign_o, 1'b1);
    chk("lit_mis_stall", stall_o, 1'b0);
    @(posedge clk); #1;
    mem_valid_i = 1'b0;
    @(negedge clk);
    chk("lit_mis_noreq", bus_req_o, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_bus_req"}, bus_req_o, 0);
    chk({tag, "_bus_we"}, bus_we_o, 0);
    chk({tag, "_bus_addr"}, bus_addr_o, 0);
    chk({tag, "_bus_wdata"}, bus_wdata_o, 0);
    chk({tag, "_bus_wstrb"}, bus_wstrb_o, 0);
    chk({tag, "_rdata"}, rdata_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_timeout"}, timeout_o, 0);
    chk({tag, "_stall"}, stall_o, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    mem_valid_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'b000; addr_i = 32'd0; wdata_i = 32'd0;
    bus_ready_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    chk_en = 1'b1;

    // T1: LW 0x100, ready after 2 cycles, rvalid 3 cycles later.
    run_access(0, 3'b010, 32'h100, 0, 2, 3, 32'hDEAD_BEEF, 0, -1,
               1, 32'hDEAD_BEEF, 0, 32'h100, 4'b0000, 0);
    // T2: LB then LBU at 0x103, back-to-back.
    run_access(0, 3'b000, 32'h103, 0, 0, 1, 32'h80FF_FFFF, 0, -1,
               1, 32'hFFFF_FF80, 0, 32'h100, 4'b0000, 0);
    run_access(0, 3'b100, 32'h103, 0, 1, 0, 32'h80FF_FFFF, 0, -1,
               1, 32'h0000_0080, 0, 32'h100, 4'b0000, 0);
    // T3: SH at 0x102.
    run_access(1, 3'b001, 32'h102, 32'h0000_ABCD, 0, 2, 32'h1234_5678, 0, -1,
               1, 32'h0, 0, 32'h100, 4'b1100, 32'hABCD_ABCD);
    // Halfword loads, with a stray rvalid before ready on the first.
    run_access(0, 3'b001, 32'h102, 0, 3, 2, 32'h8001_7FFF, 1, -1,
               1, 32'hFFFF_8001, 0, 32'h100, 4'b0000, 0);
    run_access(0, 3'b101, 32'h102, 0, 0, 0, 32'h8001_7FFF, 0, -1,
               1, 32'h0000_8001, 0, 32'h100, 4'b0000, 0);
    run_access(0, 3'b001, 32'h100, 0, 1, 1, 32'h8001_7FFF, 0, -1,
               1, 32'h0000_7FFF, 0, 32'h100, 4'b0000, 0);
    // Byte and word stores.
    run_access(1, 3'b000, 32'h101, 32'h1234_5678, 2, 0, 32'h0, 0, -1,
               1, 32'h0, 0, 32'h100, 4'b0010, 32'h7878_7878);
    run_access(1, 3'b010, 32'h200, 32'hCAFE_F00D, 0, 1, 32'hFFFF_FFFF, 0, -1,
               1, 32'h0, 0, 32'h200, 4'b1111, 32'hCAFE_F00D);

    // T4 and other misaligned accesses.
    try_misaligned(0, 3'b010, 32'h101);
    try_misaligned(0, 3'b001, 32'h103);
    try_misaligned(1, 3'b010, 32'h102);
    try_misaligned(1, 3'b001, 32'h101);

    // Completion on the very last cycle before the timeout fires.
    run_access(0, 3'b010, 32'h2F0, 0, 0, 254, 32'h0BAD_CAFE, 0, -1,
               1, 32'h0BAD_CAFE, 0, 32'h2F0, 4'b0000, 0);
    // T5: ready but no response -> timeout; then ready never given.
    run_access(0, 3'b010, 32'h300, 0, 0, NEVER, 32'h1111_1111, 0, -1,
               1, 32'h0, 1, 32'h300, 4'b0000, 0);
    run_access(1, 3'b010, 32'h304, 32'h0F0F_0F0F, NEVER, 0, 32'h0, 0, -1,
               1, 32'h0, 1, 32'h304, 4'b1111, 32'h0F0F_0F0F);

    // T6: reset while in WAIT, then a late rvalid, then a normal LW.
    run_access(0, 3'b010, 32'h400, 0, 1, NEVER, 32'h2222_2222, 0, 4,
               0, 32'h0, 0, 32'h0, 4'b0000, 0);
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'h3333_3333;
    @(negedge clk);
    check_all_zero("post_rst");
    @(posedge clk); #1;
    bus_rvalid_i = 1'b0;
    @(negedge clk);
    chk("late_rvalid_done", done_o, 1'b0);
    chk("late_rvalid_rdata", rdata_o, 32'h0);
    run_access(0, 3'b010, 32'h404, 0, 1, 1, 32'h4444_5555, 0, -1,
               1, 32'h4444_5555, 0, 32'h404, 4'b0000, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) chk("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
